dmux_rr_sched: RTL

//  Dispatch scheduler for the 16-bit 1-to-3 demultiplexer (dmuxif). Accepts words on a

---
 rtl/dmux_rr_sched_pkg.sv | 20 ++
 rtl/dmux_rr_sched_rr_pick.sv | 26 ++
 rtl/dmux_rr_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmux_rr_sched_pkg.sv
// Shared types and constants for the demux dispatch scheduler.
package dmux_rr_sched_pkg;

  localparam int unsigned NCH = 3;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } state_t;

  // One-hot channel valid from a demux select; SEL_NONE maps to all zeros.
  function automatic logic [NCH-1:0] sel_onehot(input logic [1:0] sel);
    logic [NCH-1:0] oh;
    oh = '0;
    if (sel != SEL_NONE) oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dmux_rr_sched_rr_pick.sv
// Finds the first enabled channel strictly after ptr, scanning 0,1,2 with wrap.
module dmux_rr_sched_rr_pick
  import dmux_rr_sched_pkg::*;
(
  input  logic [1:0]     ptr,
  input  logic [NCH-1:0] en,
  output logic [1:0]     sel,
  output logic           found
);

  // Scan farthest-first so the nearest enabled channel is the last to win.
  always_comb begin
    logic [1:0] idx;
    idx   = '0;
    sel   = SEL_NONE;
    found = 1'b0;
    for (int unsigned i = NCH; i >= 1; i--) begin
      idx = 2'((32'(ptr) + i) % NCH);
      if (en[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmux_rr_sched.sv
// Single-word dispatch scheduler driving a 1-to-3 demux: round-robin or fixed
// channel pick, per-channel delivery counters and a sticky stall watchdog.
module dmux_rr_sched
  import dmux_rr_sched_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned STALL_MAX = 255
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             mode,
  input  logic [1:0]       fix_sel,
  input  logic [NCH-1:0]   chan_en,
  input  logic [NCH-1:0]   sink_ready,
  output logic [DW-1:0]    dmx_in,
  output logic [1:0]       dmx_sel,
  output logic [NCH-1:0]   out_valid,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic             stall_err,
  input  logic             err_clr
);

  localparam int unsigned SW = 16;

  state_t           state_q, state_d;
  logic [DW-1:0]    data_q, data_d;
  logic [1:0]       sel_q, sel_d;
  logic [NCH-1:0]   ov_q, ov_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [SW-1:0]    stall_q, stall_d;
  logic             err_q, err_d;

  logic       held, deliver, load;
  logic [1:0] pick_ptr, pick_sel, tgt_sel;
  logic       pick_found, tgt_found;

  assign held    = (state_q == ST_HELD);
  assign deliver = held && |(sink_ready & ov_q);

  // Pointer used for the next pick already reflects a delivery this cycle.
  assign pick_ptr = (deliver && !mode) ? sel_q : ptr_q;

  dmux_rr_sched_rr_pick u_rr_pick (
    .ptr   (pick_ptr),
    .en    (chan_en),
    .sel   (pick_sel),
    .found (pick_found)
  );

  assign tgt_sel   = mode ? fix_sel : pick_sel;
  assign tgt_found = mode ? (fix_sel != SEL_NONE) : pick_found;
  assign in_ready  = tgt_found && (!held || deliver);
  assign load      = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ov_d    = ov_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    stall_d = stall_q;
    err_d   = err_q;

    if (deliver) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if (ov_q[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (!mode) ptr_d = sel_q;
      stall_d = '0;
    end else if (held) begin
      stall_d = (stall_q == '1) ? stall_q : stall_q + SW'(1);
      if (stall_d >= SW'(STALL_MAX)) err_d = 1'b1;
    end

    if (load) begin
      state_d = ST_HELD;
      data_d  = in_data;
      sel_d   = tgt_sel;
      ov_d    = sel_onehot(tgt_sel);
    end else if (deliver) begin
      state_d = ST_EMPTY;
      sel_d   = SEL_NONE;
      ov_d    = '0;
    end

    if (err_clr) begin
      stall_d = '0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      sel_q   <= SEL_NONE;
      ov_q    <= '0;
      ptr_q   <= 2'd2;
      for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ov_q    <= ov_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end

  assign dmx_in    = data_q;
  assign dmx_sel   = sel_q;
  assign out_valid = ov_q;
  assign cnt0      = cnt_q[0];
  assign cnt1      = cnt_q[1];
  assign cnt2      = cnt_q[2];
  assign stall_err = err_q;

endmodule
